// File: rtl/proj_pkg.sv
// Shared constants and types for the fragment-memory sequencer.
// Buffer geometry below sets the default FM buffer depth.
package proj_pkg;

    localparam int unsigned FM_RAMS_COUNT             = 2;
    localparam int unsigned FM_ENTRIES_COUNT          = 2;
    localparam int unsigned FM_OFFSET_COUNT           = 2;
    localparam int unsigned FM_DATA_BITS              = 32;
    localparam int unsigned SIGNED_INDICE_LEN         = 8;
    localparam int unsigned FM_EXTENDER_FRAG_LEN_BITS = 16;

    localparam int unsigned FM_BUFFER_WORDS =
        FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT;

    typedef enum logic [0:0] {
        R_IDLE,
        R_RUN
    } fm_rd_state_e;

endpackage

// File: rtl/proj_fm_fill_cnt.sv
// Write-side pacing for the FM: mirrors the FM's free-running write address,
// flags missing fill words and gates the buffer swap on the last word.
module proj_fm_fill_cnt #(
    parameter int unsigned BUFFER_WORDS = proj_pkg::FM_BUFFER_WORDS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_valid,
    input  logic swap_ok,
    input  logic fm_wait,
    output logic s_ready,
    output logic swap,
    output logic underrun
);

    localparam int unsigned WcntBits = (BUFFER_WORDS > 2) ? $clog2(BUFFER_WORDS) : 1;
    localparam logic [WcntBits-1:0] WcntLast = WcntBits'(BUFFER_WORDS - 1);

    logic [WcntBits-1:0] wcnt_q, wcnt_d;
    logic                underrun_q, underrun_d;
    logic                at_last;

    always_comb begin
        at_last    = (wcnt_q == WcntLast);
        swap       = at_last & s_valid & swap_ok;
        s_ready    = at_last ? swap : 1'b1;
        wcnt_d     = wcnt_q;
        underrun_d = underrun_q;
        // The FM consumes a word every cycle below the last slot, valid or not.
        if (!at_last) begin
            wcnt_d = wcnt_q + WcntBits'(1);
            if (!s_valid) begin
                underrun_d = 1'b1;
            end
        end else if (swap) begin
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;

    // The FM must be holding its write address while we sit on the last word.
    fm_wait_in_hold: assert property (@(posedge clk) disable iff (!rst_n) at_last |-> fm_wait);

endmodule

// File: rtl/proj_fm_ctrl.sv
// Sequencer for the ping-pong fragment memory: paces reference fills into the
// FM write buffer and runs strided fragment-query bursts from the read buffer.
module proj_fm_ctrl #(
    parameter int unsigned BUFFER_WORDS      = proj_pkg::FM_RAMS_COUNT *
                                               proj_pkg::FM_ENTRIES_COUNT *
                                               proj_pkg::FM_OFFSET_COUNT,
    parameter int unsigned DATA_BITS         = proj_pkg::FM_DATA_BITS,
    parameter int unsigned SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
    parameter int unsigned FRAG_LEN          = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
    parameter int unsigned CNT_BITS          = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_BITS-1:0]         s_data,
    input  logic                         rd_release,
    input  logic                         q_valid,
    output logic                         q_ready,
    input  logic [SIGNED_INDICE_LEN-1:0] q_start,
    input  logic [SIGNED_INDICE_LEN-1:0] q_stride,
    input  logic [CNT_BITS-1:0]          q_count,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [FRAG_LEN-1:0]          m_data,
    output logic                         m_last,
    output logic [DATA_BITS-1:0]         fm_wdata,
    output logic                         fm_chg_idx,
    output logic [SIGNED_INDICE_LEN-1:0] fm_frag_idx,
    input  logic                         fm_wait,
    input  logic [FRAG_LEN-1:0]          fm_rdata,
    output logic                         rd_buf_valid,
    output logic                         underrun
);

    import proj_pkg::*;

    fm_rd_state_e                 rd_state_q, rd_state_d;
    logic [SIGNED_INDICE_LEN-1:0] cur_q, cur_d;
    logic [SIGNED_INDICE_LEN-1:0] stride_q, stride_d;
    logic [CNT_BITS-1:0]          rem_q, rem_d;
    logic                         rd_buf_valid_q, rd_buf_valid_d;
    logic                         rel_pend_q, rel_pend_d;
    logic                         rd_idle, swap_ok, swap, q_accept, m_fire;

    assign fm_wdata   = s_data;
    assign m_data     = fm_rdata;
    assign fm_chg_idx = swap;

    proj_fm_fill_cnt #(
        .BUFFER_WORDS(BUFFER_WORDS)
    ) u_fill_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .swap_ok (swap_ok),
        .fm_wait (fm_wait),
        .s_ready (s_ready),
        .swap    (swap),
        .underrun(underrun)
    );

    always_comb begin
        rd_idle      = (rd_state_q == R_IDLE);
        // Swapping mid-burst would change the buffer under the reader.
        swap_ok      = rd_idle & (~rd_buf_valid_q | rel_pend_q);
        q_ready      = rd_idle & rd_buf_valid_q & ~rel_pend_q;
        m_valid      = (rd_state_q == R_RUN);
        m_last       = m_valid & (rem_q == CNT_BITS'(1));
        q_accept     = q_valid & q_ready;
        m_fire       = m_valid & m_ready;
        fm_frag_idx  = cur_q;
        rd_buf_valid = rd_buf_valid_q;

        rd_state_d = rd_state_q;
        cur_d      = cur_q;
        stride_d   = stride_q;
        rem_d      = rem_q;
        case (rd_state_q)
            R_IDLE: begin
                if (q_accept && (q_count != '0)) begin
                    cur_d      = q_start;
                    stride_d   = q_stride;
                    rem_d      = q_count;
                    rd_state_d = R_RUN;
                end
            end
            R_RUN: begin
                if (m_fire) begin
                    cur_d = cur_q + stride_q;
                    rem_d = rem_q - CNT_BITS'(1);
                    if (m_last) begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        rd_buf_valid_d = rd_buf_valid_q | swap;
        rel_pend_d     = swap ? 1'b0 : (rel_pend_q | (rd_release & rd_buf_valid_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q     <= R_IDLE;
            cur_q          <= '0;
            stride_q       <= '0;
            rem_q          <= '0;
            rd_buf_valid_q <= 1'b0;
            rel_pend_q     <= 1'b0;
        end else begin
            rd_state_q     <= rd_state_d;
            cur_q          <= cur_d;
            stride_q       <= stride_d;
            rem_q          <= rem_d;
            rd_buf_valid_q <= rd_buf_valid_d;
            rel_pend_q     <= rel_pend_d;
        end
    end

endmodule

// File: tb/tb_proj_fm_ctrl.sv
// Bench for proj_fm_ctrl with N=8: behavioural FM model, per-scenario tasks,
// expected fragments derived from the words the bench itself streamed.
module tb_proj_fm_ctrl;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int SL = 8;
    localparam int FL = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid, s_ready, rd_release, q_valid, q_ready;
    logic [DW-1:0] s_data, fm_wdata;
    logic [SL-1:0] q_start, q_stride, fm_frag_idx;
    logic [CW-1:0] q_count;
    logic          m_valid, m_ready, m_last, fm_chg_idx, fm_wait, rd_buf_valid, underrun;
    logic [FL-1:0] m_data, fm_rdata;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            fill_start = 0;
    logic [DW-1:0] data_tab [256];
    logic [DW-1:0] exp_buf [N];

    proj_fm_ctrl #(
        .BUFFER_WORDS(N), .DATA_BITS(DW), .SIGNED_INDICE_LEN(SL), .FRAG_LEN(FL), .CNT_BITS(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rd_release(rd_release), .q_valid(q_valid), .q_ready(q_ready), .q_start(q_start),
        .q_stride(q_stride), .q_count(q_count), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .fm_wdata(fm_wdata), .fm_chg_idx(fm_chg_idx),
        .fm_frag_idx(fm_frag_idx), .fm_wait(fm_wait), .fm_rdata(fm_rdata),
        .rd_buf_valid(rd_buf_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // FM model: free-running write address, holds on the last slot until chg_idx.
    logic [DW-1:0] fm_wbuf [N];
    logic [DW-1:0] fm_rbuf [N];
    int            fm_waddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_waddr <= 0;
        end else if (fm_waddr < N - 1) begin
            fm_wbuf[fm_waddr] <= fm_wdata;
            fm_waddr <= fm_waddr + 1;
        end else if (fm_chg_idx) begin
            for (int i = 0; i < N - 1; i++) fm_rbuf[i] <= fm_wbuf[i];
            fm_rbuf[N-1] <= fm_wdata;
            fm_waddr <= 0;
        end
    end

    assign fm_wait = (fm_waddr == N - 1);

    always_comb begin
        fm_rdata = '0;
        if (!fm_frag_idx[SL-1]) fm_rdata = fm_rbuf[fm_frag_idx[2:0]][FL-1:0] ^ {8'h00, fm_frag_idx};
    end

    function automatic logic [FL-1:0] exp_frag(input logic [SL-1:0] idx);
        if (idx[SL-1]) return '0;
        return exp_buf[idx[2:0]][FL-1:0] ^ {8'h00, idx};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        s_data = data_tab[cyc % 256];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; rd_release = 1'b0; q_valid = 1'b0; m_ready = 1'b0;
        q_start = '0; q_stride = '0; q_count = '0; s_data = '0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({s_ready, fm_chg_idx, fm_frag_idx, m_valid, m_last, q_ready, rd_buf_valid, underrun}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b chg=%b idx=%h mv=%b ml=%b qr=%b rbv=%b ur=%b",
                     s_ready, fm_chg_idx, fm_frag_idx, m_valid, m_last, q_ready, rd_buf_valid,
                     underrun);
        end
    endtask

    task automatic test_first_fill();
        @(posedge clk);
        #1;
        rst_n = 1'b1; cyc = 0; s_data = data_tab[0]; s_valid = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) step();
            #1;
            total++;
            if (fm_chg_idx !== (c == 7)) begin
                bad++; $display("FAIL fill1_chg c=%0d got=%b want=%b", c, fm_chg_idx, c == 7);
            end
            total++;
            if (s_ready !== 1'b1) begin
                bad++; $display("FAIL fill1_s_ready c=%0d got=%b want=1", c, s_ready);
            end
            total++;
            if ({rd_buf_valid, q_ready} !== {2{c == 8}}) begin
                bad++; $display("FAIL fill1_rbv_qr c=%0d got=%b%b want=%b", c, rd_buf_valid,
                                q_ready, c == 8);
            end
        end
        total++;
        if (underrun !== 1'b0) begin
            bad++; $display("FAIL fill1_underrun got=%b want=0", underrun);
        end
        for (int j = 0; j < N; j++) exp_buf[j] = data_tab[j];
        fill_start = 8;
    endtask

    task automatic test_query_basic();
        logic [SL-1:0] idx;
        step();
        q_valid = 1'b1; q_start = 8'd2; q_stride = 8'd1; q_count = 16'd3; m_ready = 1'b1;
        #1;
        total++;
        if (q_ready !== 1'b1) begin bad++; $display("FAIL q1_ready got=%b want=1", q_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            q_valid = 1'b0;
            #1;
            idx = 8'(2 + k);
            total++;
            if (m_valid !== 1'b1 || fm_frag_idx !== idx || m_last !== (k == 2) ||
                m_data !== exp_frag(idx)) begin
                bad++;
                $display("FAIL q1_beat k=%0d mv=%b idx got=%h want=%h last got=%b data got=%h want=%h",
                         k, m_valid, fm_frag_idx, idx, m_last, m_data, exp_frag(idx));
            end
        end
        step();
        #1;
        total++;
        if ({m_valid, q_ready} !== 2'b01) begin
            bad++; $display("FAIL q1_done got mv=%b qr=%b want mv=0 qr=1", m_valid, q_ready);
        end
    endtask

    task automatic test_query_stall();
        logic [SL-1:0] idx;
        step();
        q_valid = 1'b1; q_start = 8'hFE; q_stride = 8'd3; q_count = 16'd2; m_ready = 1'b0;
        #1;
        total++;
        if (q_ready !== 1'b1) begin bad++; $display("FAIL q2_ready got=%b want=1", q_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            q_valid = 1'b0;
            m_ready = (c >= 2);
            #1;
            idx = (c < 3) ? 8'hFE : 8'h01;
            total++;
            if (m_valid !== 1'b1 || fm_frag_idx !== idx || m_last !== (c == 3) ||
                m_data !== exp_frag(idx)) begin
                bad++;
                $display("FAIL q2_beat c=%0d mv=%b idx got=%h want=%h last got=%b data got=%h want=%h",
                         c, m_valid, fm_frag_idx, idx, m_last, m_data, exp_frag(idx));
            end
        end
        step();
        m_ready = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL q2_done mv got=%b want=0", m_valid); end
    endtask

    task automatic test_release_swap();
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            total++;
            if ({s_ready, fm_chg_idx, q_ready} !== 3'b001) begin
                bad++; $display("FAIL hold c=%0d got rdy=%b chg=%b qr=%b want 0 0 1", c, s_ready,
                                fm_chg_idx, q_ready);
            end
        end
        step();
        rd_release = 1'b1;
        #1;
        total++;
        if ({fm_chg_idx, q_ready} !== 2'b01) begin
            bad++; $display("FAIL release_cycle got chg=%b qr=%b want 0 1", fm_chg_idx, q_ready);
        end
        step();
        rd_release = 1'b0;
        #1;
        total++;
        if ({fm_chg_idx, s_ready, q_ready} !== 3'b110) begin
            bad++; $display("FAIL swap2 got chg=%b rdy=%b qr=%b want 1 1 0", fm_chg_idx, s_ready,
                            q_ready);
        end
        for (int j = 0; j < N - 1; j++) exp_buf[j] = data_tab[(fill_start + j) % 256];
        exp_buf[N-1] = data_tab[cyc % 256];
        fill_start = cyc + 1;
        step();
        #1;
        total++;
        if ({fm_chg_idx, q_ready, rd_buf_valid} !== 3'b011) begin
            bad++; $display("FAIL after_swap2 got chg=%b qr=%b rbv=%b want 0 1 1", fm_chg_idx,
                            q_ready, rd_buf_valid);
        end
    endtask

    task automatic test_release_in_burst();
        logic [SL-1:0] idx;
        int            cnt, beat, guard;
        step();
        cnt = 10 + $urandom_range(0, 4);
        q_valid = 1'b1; q_start = 8'($urandom); q_stride = 8'($urandom); q_count = 16'(cnt);
        #1;
        total++;
        if (q_ready !== 1'b1) begin bad++; $display("FAIL q3_ready got=%b want=1", q_ready); end
        idx = q_start; beat = 0; guard = 0;
        while (beat < cnt && guard < 200) begin
            step();
            q_valid = 1'b0;
            m_ready = ($urandom_range(0, 3) != 0);
            rd_release = (guard == 1);
            #1;
            total++;
            if (m_valid !== 1'b1 || fm_frag_idx !== idx || m_last !== (beat == cnt - 1) ||
                m_data !== exp_frag(idx)) begin
                bad++;
                $display("FAIL q3_beat b=%0d mv=%b idx got=%h want=%h last got=%b data got=%h want=%h",
                         beat, m_valid, fm_frag_idx, idx, m_last, m_data, exp_frag(idx));
            end
            total++;
            if (fm_chg_idx !== 1'b0) begin
                bad++; $display("FAIL q3_swap_in_run b=%0d got=%b want=0", beat, fm_chg_idx);
            end
            if (m_ready) begin beat++; idx = idx + q_stride; end
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++; $display("FAIL q3_timeout beats got=%0d want=%0d", beat, cnt);
        end
        step();
        m_ready = 1'b0; rd_release = 1'b0;
        #1;
        total++;
        if ({fm_chg_idx, m_valid, q_ready} !== 3'b100) begin
            bad++; $display("FAIL deferred_swap got chg=%b mv=%b qr=%b want 1 0 0", fm_chg_idx,
                            m_valid, q_ready);
        end
        for (int j = 0; j < N - 1; j++) exp_buf[j] = data_tab[(fill_start + j) % 256];
        exp_buf[N-1] = data_tab[cyc % 256];
        fill_start = cyc + 1;
        step();
        #1;
        total++;
        if (q_ready !== 1'b1) begin bad++; $display("FAIL q3_after got qr=%b want=1", q_ready); end
    endtask

    task automatic test_random_queries();
        logic [SL-1:0] idx;
        int            cnt, beat, guard;
        for (int q = 0; q < 8; q++) begin
            step();
            cnt = (q == 2) ? 0 : $urandom_range(0, 5);
            q_valid = 1'b1; q_start = 8'($urandom); q_stride = 8'($urandom); q_count = 16'(cnt);
            m_ready = 1'b0;
            #1;
            total++;
            if (q_ready !== 1'b1) begin bad++; $display("FAIL rq_ready q=%0d got=%b want=1", q, q_ready); end
            idx = q_start; beat = 0; guard = 0;
            while (beat < cnt && guard < 200) begin
                step();
                q_valid = 1'b0;
                m_ready = ($urandom_range(0, 2) != 0);
                #1;
                total++;
                if (m_valid !== 1'b1 || fm_frag_idx !== idx || m_last !== (beat == cnt - 1) ||
                    m_data !== exp_frag(idx) || fm_chg_idx !== 1'b0) begin
                    bad++;
                    $display("FAIL rq_beat q=%0d b=%0d mv=%b idx got=%h want=%h last=%b data got=%h want=%h chg=%b",
                             q, beat, m_valid, fm_frag_idx, idx, m_last, m_data, exp_frag(idx),
                             fm_chg_idx);
                end
                if (m_ready) begin beat++; idx = idx + q_stride; end
                guard++;
            end
            if (guard >= 200) begin
                total++; bad++; $display("FAIL rq_timeout q=%0d got=%0d want=%0d", q, beat, cnt);
            end
            step();
            q_valid = 1'b0; m_ready = 1'b0;
            #1;
            total++;
            if ({m_valid, q_ready} !== 2'b01) begin
                bad++; $display("FAIL rq_done q=%0d got mv=%b qr=%b want 0 1", q, m_valid, q_ready);
            end
        end
    endtask

    task automatic test_underrun_and_async_reset();
        step();
        rst_n = 1'b0; q_valid = 1'b0; m_ready = 1'b0; rd_release = 1'b0;
        step();
        rst_n = 1'b1; cyc = 0; s_data = data_tab[0];
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) step();
            s_valid = (c != 3);
            #1;
            total++;
            if ({underrun, fm_chg_idx} !== {c >= 4, c == 7}) begin
                bad++; $display("FAIL underrun c=%0d got ur=%b chg=%b want ur=%b chg=%b", c,
                                underrun, fm_chg_idx, c >= 4, c == 7);
            end
        end
        q_valid = 1'b1; q_start = 8'd5; q_stride = 8'd1; q_count = 16'd3;
        step();
        q_valid = 1'b0;
        #1;
        total++;
        if ({m_valid, fm_frag_idx, underrun} !== {1'b1, 8'd5, 1'b1}) begin
            bad++; $display("FAIL pre_reset got mv=%b idx=%h ur=%b want 1 05 1", m_valid,
                            fm_frag_idx, underrun);
        end
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, fm_chg_idx, fm_frag_idx, m_valid, m_last, q_ready, rd_buf_valid, underrun}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got rdy=%b chg=%b idx=%h mv=%b ml=%b qr=%b rbv=%b ur=%b",
                     s_ready, fm_chg_idx, fm_frag_idx, m_valid, m_last, q_ready, rd_buf_valid,
                     underrun);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) data_tab[i] = (i < 8) ? DW'(i + 1) : $urandom;
        test_reset();
        test_first_fill();
        test_query_basic();
        test_query_stall();
        test_release_swap();
        test_release_in_burst();
        test_random_queries();
        test_underrun_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proj_fm_ctrl.md
# proj_fm_ctrl

Sequencer for the ping-pong fragment memory (FM). It streams reference words into the FM write buffer in lockstep with the FM's free-running write address, and issues the single-cycle `chg_idx` swap only when a fill is complete and the read side has released its buffer. It also runs strided fragment-query bursts by driving `frag_idx` and returning `fm_rdata` over a valid/ready stream. It sits between the reference loader and the FM on one side, and the fragment consumer (hash stage) on the other.

## Interface
- `BUFFER_WORDS`, default `proj_pkg::FM_RAMS_COUNT*FM_ENTRIES_COUNT*FM_OFFSET_COUNT`, FM words per buffer (N); must be ≥2.
- `DATA_BITS`, default `proj_pkg::FM_DATA_BITS`, FM word width.
- `SIGNED_INDICE_LEN`, default `proj_pkg::SIGNED_INDICE_LEN`, signed fragment index width.
- `FRAG_LEN`, default `proj_pkg::FM_EXTENDER_FRAG_LEN_BITS`, fragment width in bits.
- `CNT_BITS`, default 16, query count width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1, `s_ready` out 1, `s_data` in DATA_BITS: reference word stream.
- `rd_release` in 1: pulse; consumer is finished with the current read buffer.
- `q_valid` in 1, `q_ready` out 1: query handshake.
- `q_start` in SIGNED_INDICE_LEN: first fragment index (signed).
- `q_stride` in SIGNED_INDICE_LEN: index step (signed).
- `q_count` in CNT_BITS: number of fragments.
- `m_valid` out 1, `m_ready` in 1, `m_data` out FRAG_LEN, `m_last` out 1: fragment stream.
- `fm_wdata` out DATA_BITS, `fm_chg_idx` out 1, `fm_frag_idx` out SIGNED_INDICE_LEN: to FM.
- `fm_wait` in 1, `fm_rdata` in FRAG_LEN: from FM.
- `rd_buf_valid` out 1: read buffer holds a complete reference.
- `underrun` out 1: sticky, set when a fill word was missing.

## Operation
- `fm_wdata = s_data` combinationally; `m_data = fm_rdata` combinationally.
- Write counter `wcnt` (0..N-1) mirrors the FM write address. It leaves reset at 0 and advances every cycle while `wcnt < N-1`.
- `wcnt < N-1`: `s_ready = 1`. If `s_valid = 0`, the word is still consumed by the FM and `underrun` sets (cleared only by reset).
- `wcnt = N-1` is the FM hold state, in which `fm_wait` must be 1. The FM writes the last word only in the cycle `fm_chg_idx` is high.
- `swap = (wcnt == N-1) & s_valid & (rd_state == R_IDLE) & (~rd_buf_valid | rel_pend)`.
- `s_ready = swap` and `fm_chg_idx = swap` in this state; `wcnt` stays at N-1 until `swap`, then goes to 0.
- `fm_chg_idx` is never asserted outside `swap`.
- On `swap`: `rd_buf_valid` is set and `rel_pend` is cleared.
- `rel_pend` is set by `rd_release` while `rd_buf_valid`. If `rd_release` arrives in the swap cycle, it is dropped.
- Read FSM has two states, R_IDLE and R_RUN.
  - `q_ready = (R_IDLE) & rd_buf_valid & ~rel_pend`.
  - On accept with `q_count = 0`: stay in R_IDLE, emit nothing.
  - On accept with `q_count ≥ 1`: `cur = q_start`, `rem = q_count`, go to R_RUN.
- In R_RUN:
  - `fm_frag_idx = cur`, `m_valid = 1`, `m_last = (rem == 1)`.
  - On `m_ready`: `cur += q_stride` (two's-complement wrap at SIGNED_INDICE_LEN) and `rem -= 1`.
  - On the `m_last` handshake, return to R_IDLE.
- `fm_frag_idx` holds its last value in R_IDLE. Negative indices are passed through, since the FM zero-pads them.
- A swap cannot occur in R_RUN, so a burst always reads one buffer.

## Timing
- Reset values: `wcnt=0`, R_IDLE, `cur=0`, `rem=0`, `rd_buf_valid=0`, `rel_pend=0`, `underrun=0`.
  - Outputs after reset: `s_ready=1`, `fm_chg_idx=0`, `fm_frag_idx=0`, `m_valid=0`, `m_last=0`, `q_ready=0`.
- Reset must be applied to this block and the FM together, so the counters stay aligned.
- The first fill takes N cycles: words 0..N-2 in cycles 0..N-2, and word N-1 plus swap in cycle N-1 if `s_valid`.
- The next fill starts the cycle after swap.
- `q_ready` is high the cycle after the first swap.
- Query latency: accept in cycle t, first fragment valid in cycle t+1. Throughput is one fragment per cycle under `m_ready=1`.
- With `m_valid & ~m_ready`, `fm_frag_idx`, `m_data` and `m_last` are stable.
- `rd_release` is registered: `q_ready` drops the following cycle.

## Structure
- `proj_pkg` holds the `BUFFER_WORDS` derivation and a `fm_rd_state_e` typedef (R_IDLE, R_RUN).
- One optional sub-module, `proj_fm_fill_cnt`, implements the write counter, underrun detection and the swap gate. The read FSM is written inline.

## Test plan
All scenarios use N=8 (2×2×2).
1. Reset, then stream 0x1..0x8 continuously → `fm_chg_idx` pulses in cycle 7 only; `rd_buf_valid=1` in cycle 8; `underrun=0`.
2. Query start=2, stride=1, count=3 with `m_ready=1` → `fm_frag_idx` = 2, 3, 4 on consecutive cycles; `m_last` on index 4; data matches the FM model.
3. Query start=-2, stride=3, count=2 with `m_ready` low for 2 cycles on the first beat → `fm_frag_idx` holds -2 for 3 cycles, then 1; `m_last` on 1.
4. Second fill completes while `rd_release` is not given → `wcnt` holds at N-1, `s_ready=0`. `rd_release` at cycle t → swap at t+1 when `s_valid`; `q_ready` stays low from t+1 until after the swap.
5. `rd_release` and a complete fill while in R_RUN → swap is deferred until the cycle after the `m_last` handshake.
6. `s_valid` low at `wcnt=3` → `underrun` goes to 1 and stays set; `wcnt` still reaches 7 on schedule. Asserting `rst_n=0` mid-fill → all outputs return to their reset values asynchronously.
